// File: rtl/speed_clk_pkg.sv
// Shared band constants and the speed-code to half-period decode used by every channel.
package speed_clk_pkg;

  localparam int unsigned DEF_HALF_SLOW  = 80;
  localparam int unsigned DEF_HALF_MID   = 40;
  localparam int unsigned DEF_HALF_FAST  = 10;
  localparam int unsigned DEF_MID_START  = 6;
  localparam int unsigned DEF_FAST_START = 11;

  // Width-agnostic decode; callers cast the result down to their counter width.
  function automatic int unsigned dec_half(
    input int unsigned code,
    input int unsigned half_slow,
    input int unsigned half_mid,
    input int unsigned half_fast,
    input int unsigned mid_start,
    input int unsigned fast_start
  );
    if (code == 0)               return 0;
    else if (code < mid_start)   return half_slow;
    else if (code < fast_start)  return half_mid;
    else                         return half_fast;
  endfunction

endpackage

// File: rtl/speed_clk_chan.sv
// One divider channel: half-period counter, active half register, div_clk and tick.
module speed_clk_chan
  import speed_clk_pkg::*;
#(
  parameter int unsigned SPEED_W    = 4,
  parameter int unsigned CNT_W      = 20,
  parameter int unsigned HALF_SLOW  = DEF_HALF_SLOW,
  parameter int unsigned HALF_MID   = DEF_HALF_MID,
  parameter int unsigned HALF_FAST  = DEF_HALF_FAST,
  parameter int unsigned MID_START  = DEF_MID_START,
  parameter int unsigned FAST_START = DEF_FAST_START
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_sync,
  input  logic [SPEED_W-1:0] i_speed,
  output logic               o_div_clk,
  output logic               o_tick,
  output logic               o_running
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_half;
  logic             r_div;
  logic             r_tick;
  logic [CNT_W-1:0] w_dec;
  logic             w_bound;

  assign w_dec   = CNT_W'(dec_half(32'(i_speed), HALF_SLOW, HALF_MID, HALF_FAST,
                                   MID_START, FAST_START));
  assign w_bound = (r_cnt == r_half - CNT_W'(1));

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt  <= '0;
      r_half <= '0;
      r_div  <= 1'b0;
      r_tick <= 1'b0;
    end else if (i_sync || (r_half == '0)) begin
      r_cnt  <= '0;
      r_div  <= 1'b0;
      r_tick <= 1'b0;
      r_half <= w_dec;
    end else begin
      r_tick <= 1'b0;
      if (w_bound) begin
        r_cnt <= '0;
        r_div <= ~r_div;
        if (!r_div) begin
          // A stop request on the rising edge is deferred so the high half completes.
          r_tick <= 1'b1;
          if (w_dec != '0) r_half <= w_dec;
        end else begin
          r_half <= w_dec;
        end
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_div_clk = r_div;
  assign o_tick    = r_tick;
  assign o_running = (r_half != '0);

endmodule

// File: rtl/speed_clk_gen.sv
// Multi-channel speed-selectable clock divider: slices the speed bus and fans out sync.
module speed_clk_gen
  import speed_clk_pkg::*;
#(
  parameter int unsigned N_CH       = 2,
  parameter int unsigned SPEED_W    = 4,
  parameter int unsigned CNT_W      = 20,
  parameter int unsigned HALF_SLOW  = DEF_HALF_SLOW,
  parameter int unsigned HALF_MID   = DEF_HALF_MID,
  parameter int unsigned HALF_FAST  = DEF_HALF_FAST,
  parameter int unsigned MID_START  = DEF_MID_START,
  parameter int unsigned FAST_START = DEF_FAST_START
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    sync,
  input  logic [N_CH*SPEED_W-1:0] speed,
  output logic [N_CH-1:0]         div_clk,
  output logic [N_CH-1:0]         tick,
  output logic [N_CH-1:0]         running
);

  localparam longint unsigned CNT_LIM  = 64'd1 << CNT_W;
  localparam longint unsigned CODE_MAX = (64'd1 << SPEED_W) - 64'd1;

  if (HALF_SLOW < 1 || 64'(HALF_SLOW) >= CNT_LIM ||
      HALF_MID  < 1 || 64'(HALF_MID)  >= CNT_LIM ||
      HALF_FAST < 1 || 64'(HALF_FAST) >= CNT_LIM) begin : g_bad_half
    $error("speed_clk_gen: half-period parameter out of range");
  end

  if (MID_START <= 1 || FAST_START <= MID_START ||
      64'(FAST_START) > CODE_MAX) begin : g_bad_band
    $error("speed_clk_gen: speed band starts out of range");
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    speed_clk_chan #(
      .SPEED_W   (SPEED_W),
      .CNT_W     (CNT_W),
      .HALF_SLOW (HALF_SLOW),
      .HALF_MID  (HALF_MID),
      .HALF_FAST (HALF_FAST),
      .MID_START (MID_START),
      .FAST_START(FAST_START)
    ) u_chan (
      .i_clk    (clk),
      .i_rst_n  (rst_n),
      .i_sync   (sync),
      .i_speed  (speed[g*SPEED_W +: SPEED_W]),
      .o_div_clk(div_clk[g]),
      .o_tick   (tick[g]),
      .o_running(running[g])
    );
  end

endmodule

// File: tb/tb_speed_clk_gen.sv
// Directed bench for speed_clk_gen: decode table plus start/stop/sync/reset sequences.
module tb_speed_clk_gen;

  logic       clk;
  logic       rst_n;
  logic       sync;
  logic [7:0] speed;
  logic [1:0] div_clk;
  logic [1:0] tick;
  logic [1:0] running;

  int checks = 0;
  int errors = 0;

  speed_clk_gen dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .sync   (sync),
    .speed  (speed),
    .div_clk(div_clk),
    .tick   (tick),
    .running(running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] code;
    int         half;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_spd(input int ch, input logic [3:0] v);
    speed[ch*4 +: 4] = v;
  endtask

  // Cycles until the channel's tick is seen high; -1 if the budget expires.
  task automatic wait_tick(input int ch, input int max, output int n);
    n = -1;
    for (int i = 1; i <= max && n < 0; i++) begin
      @(negedge clk);
      if (tick[ch]) n = i;
    end
  endtask

  task automatic wait_fall(input int ch, input int max, output int n);
    n = -1;
    for (int i = 1; i <= max && n < 0; i++) begin
      @(negedge clk);
      if (!div_clk[ch]) n = i;
    end
  endtask

  task automatic count_hi(input int ch, input int cycles, output int nt, output int nd);
    nt = 0;
    nd = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (tick[ch]) nt++;
      if (div_clk[ch]) nd++;
    end
  endtask

  task automatic do_reset(input logic [7:0] spd);
    rst_n = 1'b0;
    sync  = 1'b0;
    speed = spd;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  vec_t vecs[7];
  int   n, nt, nd, mis;

  initial begin
    vecs[0] = '{4'd5,  80};
    vecs[1] = '{4'd6,  40};
    vecs[2] = '{4'd10, 40};
    vecs[3] = '{4'd11, 10};
    vecs[4] = '{4'd15, 10};
    vecs[5] = '{4'd1,  80};
    vecs[6] = '{4'd7,  40};

    rst_n = 1'b0;
    sync  = 1'b0;
    speed = '0;
    repeat (3) @(negedge clk);
    chk("rst_div_clk", int'(div_clk), 0);
    chk("rst_tick",    int'(tick),    0);
    chk("rst_running", int'(running), 0);

    // Start ch0 at a fast code, ch1 stays stopped.
    set_spd(0, 4'd12);
    rst_n = 1'b1;
    @(negedge clk);
    chk("start_run0", int'(running[0]), 1);
    chk("start_run1", int'(running[1]), 0);
    wait_tick(0, 100, n);  chk("start_first_rise", n, 10);
    @(negedge clk);
    chk("start_tick_width", int'(tick[0]), 0);
    wait_fall(0, 100, n);  chk("start_high_len", n, 9);
    wait_tick(0, 100, n);  chk("start_low_len", n, 10);
    wait_tick(0, 100, n);  chk("start_period", n, 20);
    count_hi(0, 60, nt, nd);
    chk("start_ticks_60", nt, 3);
    chk("start_high_60", nd, 30);
    count_hi(1, 60, nt, nd);
    chk("ch1_ticks", nt, 0);
    chk("ch1_div_high", nd, 0);
    chk("ch1_running", int'(running[1]), 0);

    // Decode bands: load-to-first-rise, period and high length per code.
    for (int v = 0; v < 7; v++) begin
      do_reset({4'd0, vecs[v].code});
      wait_tick(0, 400, n);
      chk($sformatf("dec%0d_first", vecs[v].code), n, vecs[v].half + 1);
      wait_fall(0, 400, n);
      chk($sformatf("dec%0d_high", vecs[v].code), n, vecs[v].half);
      wait_tick(0, 400, n);
      chk($sformatf("dec%0d_low", vecs[v].code), n, vecs[v].half);
      wait_tick(0, 400, n);
      chk($sformatf("dec%0d_period", vecs[v].code), n, 2 * vecs[v].half);
    end

    // Slow to fast at cnt=20 of a low half: low half keeps its full 80 cycles.
    do_reset({4'd0, 4'd3});
    wait_tick(0, 400, n);  chk("chg_first", n, 81);
    wait_fall(0, 400, n);  chk("chg_high_slow", n, 80);
    repeat (20) @(negedge clk);
    set_spd(0, 4'd12);
    wait_tick(0, 400, n);  chk("chg_low_rest", n, 60);
    wait_fall(0, 400, n);  chk("chg_high_fast", n, 10);
    wait_tick(0, 400, n);  chk("chg_low_fast", n, 10);
    wait_tick(0, 400, n);  chk("chg_period_fast", n, 20);

    // Stop while high: high half completes, then parks low.
    repeat (4) @(negedge clk);
    set_spd(0, 4'd0);
    wait_fall(0, 100, n);  chk("stophi_fall", n, 6);
    chk("stophi_running", int'(running[0]), 0);
    count_hi(0, 100, nt, nd);
    chk("stophi_ticks", nt, 0);
    chk("stophi_div_high", nd, 0);

    // Stop while low: still rises, high half at old rate, then stops.
    set_spd(0, 4'd12);
    wait_tick(0, 100, n);  chk("stoplo_restart", n, 11);
    wait_fall(0, 100, n);  chk("stoplo_high1", n, 10);
    repeat (3) @(negedge clk);
    set_spd(0, 4'd0);
    wait_tick(0, 100, n);  chk("stoplo_rise", n, 7);
    wait_fall(0, 100, n);  chk("stoplo_high2", n, 10);
    chk("stoplo_running", int'(running[0]), 0);
    count_hi(0, 60, nt, nd);
    chk("stoplo_ticks", nt, 0);

    // Sync pulse aligns two equal-speed channels started 13 cycles apart.
    do_reset({4'd0, 4'd7});
    repeat (13) @(negedge clk);
    set_spd(1, 4'd7);
    repeat (30) @(negedge clk);
    sync = 1'b1;
    @(negedge clk);
    sync = 1'b0;
    chk("sync_div_clk", int'(div_clk), 0);
    chk("sync_tick", int'(tick), 0);
    chk("sync_running", int'(running), 3);
    wait_tick(0, 200, n);  chk("sync_first_rise", n, 40);
    chk("sync_tick1", int'(tick[1]), 1);
    mis = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (div_clk[0] != div_clk[1] || tick[0] != tick[1]) mis++;
    end
    chk("sync_aligned", mis, 0);

    // Sync held high keeps every channel parked at phase zero.
    sync = 1'b1;
    mis = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (div_clk != 2'b00 || tick != 2'b00) mis++;
    end
    chk("sync_hold_quiet", mis, 0);
    sync = 1'b0;
    wait_tick(0, 200, n);  chk("sync_release_rise", n, 40);
    chk("sync_release_tick1", int'(tick[1]), 1);

    // One-cycle reset in the middle of a high half.
    do_reset({4'd0, 4'd12});
    wait_tick(0, 100, n);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_div_clk", int'(div_clk[0]), 0);
    chk("midrst_tick", int'(tick[0]), 0);
    chk("midrst_running", int'(running[0]), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_restart", int'(running[0]), 1);
    wait_tick(0, 100, n);  chk("midrst_first_rise", n, 10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
